vga_sync_out: RTL and testbench

VGA_SYNC_OUT -- requirements
Module: vga_sync_out

---
 rtl/vga_sync_out.sv | 96 +++++++++
 tb/tb_vga_sync_out.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_out.sv
// ============================================================================
// Module   : vga_sync_out
// Brief    : VGA raster timing counters with registered TinyVGA PMOD output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [5:0] rgb,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       frame_start,
  output logic [7:0] uo_out
);

  localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] c_h_last     = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last     = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
  localparam logic [9:0] c_hs_first   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] c_hs_last    = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_vs_first   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] c_vs_last    = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [7:0] c_uo_idle    = 8'h88;

  logic [9:0] r_hpos;
  logic [9:0] r_vpos;
  logic [7:0] r_uo_out;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_display_on;
  logic [5:0] w_color;
  logic [7:0] w_uo_next;

  assign w_h_wrap = (r_hpos == c_h_last);
  assign w_v_wrap = (r_vpos == c_v_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (ena) begin
      if (w_h_wrap) begin
        r_hpos <= '0;
        r_vpos <= w_v_wrap ? '0 : r_vpos + 10'd1;
      end else begin
        r_hpos <= r_hpos + 10'd1;
      end
    end
  end

  // Sync pulses are active low inside their window.
  assign w_hsync      = !((r_hpos >= c_hs_first) && (r_hpos <= c_hs_last));
  assign w_vsync      = !((r_vpos >= c_vs_first) && (r_vpos <= c_vs_last));
  assign w_display_on = (r_hpos < c_h_active) && (r_vpos < c_v_active);
  assign w_color      = w_display_on ? rgb : 6'd0;

  assign w_uo_next = {w_hsync, w_color[1], w_color[3], w_color[5],
                      w_vsync, w_color[0], w_color[2], w_color[4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo_out <= c_uo_idle;
    end else if (ena) begin
      r_uo_out <= w_uo_next;
    end
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign display_on  = w_display_on;
  assign frame_start = ena && (r_hpos == 10'd0) && (r_vpos == 10'd0);
  assign uo_out      = r_uo_out;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_out.sv
// ============================================================================
// Module   : tb_vga_sync_out
// Brief    : Self-checking bench for vga_sync_out using reduced raster sizes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_out;

  localparam int HA = 20;
  localparam int HF = 3;
  localparam int HS = 5;
  localparam int HB = 4;
  localparam int VA = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [5:0] rgb;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       frame_start;
  logic [7:0] uo_out;

  vga_sync_out #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rgb        (rgb),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .frame_start(frame_start),
    .uo_out     (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: linear pixel index within the frame plus the last output word.
  int         m_idx;
  logic [7:0] m_uo;
  logic       last_fs;

  typedef struct {
    logic       e;
    logic [5:0] c;
    int         h;
    int         v;
    logic [7:0] uo;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_word(input int h, input int v, input logic [5:0] c);
    logic       hs, vs;
    logic [5:0] k;
    hs = !(h >= HA + HF && h < HA + HF + HS);
    vs = !(v >= VA + VF && v < VA + VF + VS);
    k  = (h < HA && v < VA) ? c : 6'd0;
    return {hs, k[1], k[3], k[5], vs, k[0], k[2], k[4]};
  endfunction

  task automatic tick(input logic e, input logic [5:0] c);
    int h, v;
    @(negedge clk);
    ena = e;
    rgb = c;
    #1;
    h = m_idx % HT;
    v = m_idx / HT;
    last_fs = frame_start;
    check("display_on", int'(display_on), int'(h < HA && v < VA));
    check("frame_start", int'(frame_start), int'(e && m_idx == 0));
    @(posedge clk);
    if (e) begin
      m_uo  = ref_word(h, v, c);
      m_idx = (m_idx + 1) % FRAME;
    end
    #1;
    check("hpos", int'(hpos), m_idx % HT);
    check("vpos", int'(vpos), m_idx / HT);
    check("uo_out", int'(uo_out), int'(m_uo));
  endtask

  task automatic run_to(input int target);
    while (m_idx != target) tick(1'b1, 6'($urandom));
  endtask

  initial begin
    int cnt_a, cnt_b;

    tbl[0] = '{1'b1, 6'h3F, 1, 0, 8'hFF};
    tbl[1] = '{1'b1, 6'h15, 2, 0, 8'h8F};
    tbl[2] = '{1'b0, 6'h3F, 2, 0, 8'h8F};
    tbl[3] = '{1'b1, 6'h2A, 3, 0, 8'hF8};
    tbl[4] = '{1'b1, 6'h00, 4, 0, 8'h88};

    rst_n = 1'b0;
    ena   = 1'b0;
    rgb   = 6'd0;
    m_idx = 0;
    m_uo  = 8'h88;
    #12;
    check("rst_hpos", int'(hpos), 0);
    check("rst_vpos", int'(vpos), 0);
    check("rst_uo_out", int'(uo_out), 8'h88);
    check("rst_frame_start", int'(frame_start), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick(tbl[i].e, tbl[i].c);
      check("tbl_hpos", int'(hpos), tbl[i].h);
      check("tbl_vpos", int'(vpos), tbl[i].v);
      check("tbl_uo_out", int'(uo_out), int'(tbl[i].uo));
    end

    // One full line from hpos=0: hsync must be low for exactly HS output samples.
    run_to(HT);
    cnt_a = 0;
    for (int i = 0; i < HT; i++) begin
      tick(1'b1, 6'h3F);
      if (!uo_out[7]) cnt_a++;
    end
    check("hsync_low_count", cnt_a, HS);

    // Freeze mid-line, then at the frame origin where frame_start must stay low.
    run_to(HT + 12);
    for (int i = 0; i < 10; i++) tick(1'b0, 6'($urandom));
    tick(1'b1, 6'h3F);
    check("resume_hpos", int'(hpos), 13);
    run_to(0);
    for (int i = 0; i < 3; i++) tick(1'b0, 6'h3F);

    // Full frame: one frame_start pulse, vsync low for VS lines.
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1, 6'($urandom));
      if (last_fs) cnt_a++;
      if (!uo_out[3]) cnt_b++;
    end
    check("frame_start_count", cnt_a, 1);
    check("vsync_low_count", cnt_b, VS * HT);

    // Asynchronous reset between clock edges mid-frame.
    run_to(3 * HT + 10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    ena   = 1'b0;
    #1;
    m_idx = 0;
    m_uo  = 8'h88;
    check("async_rst_hpos", int'(hpos), 0);
    check("async_rst_vpos", int'(vpos), 0);
    check("async_rst_uo_out", int'(uo_out), 8'h88);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 6'h00);
    check("post_rst_hpos", int'(hpos), 1);
    check("post_rst_vpos", int'(vpos), 0);

    for (int i = 0; i < 1500; i++) tick($urandom_range(3) != 0, 6'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
